rx_deframer: RTL and testbench
==============================

// Module: rx_deframer
// PURPOSE
//  Receive-side counterpart of the Tx packetizer/bit-flattener chain. Takes hard-decision
//  demodulated bits (one strobe per bit), hunts for the 32-bit sync word (true or inverted,
//  resolving PSK 180-degree ambiguity), reads a 16-bit payload length, and emits the payload
//  as an 8-bit AXI-Stream frame. Sits between the PSK demodulator and the Rx data FIFO.
// PARAMETERS
//  SYNC_WORD  32'h1ACF_FC1D  frame sync word, sent MSB first
//  SYNC_TOL   2              max bit mismatches accepted in sync match; legal range 0..7
//  MAX_LEN    16'd1024       largest legal payload length in bytes
// PORTS
//  clk_16M384      in   1   sole clock
//  rst_16M384      in   1   reset, asynchronous, active-high
//  rx_en           in   1   1 = deframing enabled; 0 = abort and hold in HUNT
//  rx_bit          in   1   demodulated bit; sampled only when rx_bit_vld=1
//  rx_bit_vld      in   1   bit strobe, at most one bit per cycle
//  rx_tdata        out  8   payload byte, first received bit = bit 7
//  rx_tvalid       out  1   AXI-S valid
//  rx_tready       in   1   AXI-S ready
//  rx_tlast        out  1   marks last payload byte
//  rx_tuser        out  1   marks first payload byte
//  payload_length  out  16  length field of the current/last accepted header
//  hdr_vld         out  1   1-cycle pulse: valid header accepted
//  pld_vld         out  1   level: high while in PLD state
//  polarity        out  1   1 = inverted sync matched; all following bits are inverted
//  frame_err       out  1   1-cycle pulse: bad length, overflow, or abort while rx_en=0
//  frame_cnt       out  16  count of completed frames, wraps at 16'hFFFF
// BEHAVIOUR
//  Reset: state=HUNT; shift register=0; all outputs 0.
//  HUNT: each strobe shifts rx_bit in at the LSB of the 32-bit sreg.
//   - Match test uses the updated sreg: popcount(sreg^SYNC_WORD) <= SYNC_TOL.
//     On match, polarity<=0 and the block goes to LEN.
//   - Else popcount(~sreg^SYNC_WORD) <= SYNC_TOL: polarity<=1, go to LEN.
//   - SYNC_TOL<=7 guarantees both tests cannot pass at once.
//   - sreg is cleared on every entry to HUNT, so 32 fresh bits are needed before a match.
//  LEN: collects 16 bits (each rx_bit^polarity), MSB first. On the 16th bit:
//   - len==0 or len>MAX_LEN: frame_err pulse, go to HUNT, payload_length unchanged.
//   - otherwise: payload_length<=len, hdr_vld pulse, pld_vld<=1, byte count=0, go to PLD.
//  PLD: 8 bits form a byte. The byte is loaded into the output register on the cycle after
//   the strobe that carries its 8th bit (latency 1 clock).
//   - Load is allowed when rx_tvalid=0, or when rx_tvalid&rx_tready in that same cycle.
//   - On load: rx_tvalid=1; rx_tuser=(byte#==0); rx_tlast=(byte#==payload_length-1).
//   - After the last byte loads: frame_cnt+1, pld_vld<=0, go to HUNT.
//  Overflow: byte complete while output register is held (rx_tvalid & ~rx_tready).
//   - The new byte is dropped; frame_err pulse; go to HUNT.
//   - The held byte stays stable until accepted; the frame is truncated with no tlast.
//     The consumer discards on frame_err.
//  AXI rule: rx_tdata/rx_tlast/rx_tuser never change while rx_tvalid & ~rx_tready.
//   rx_tvalid drops on handshake unless a new byte loads in the same cycle.
//  rx_en=0: go to HUNT next cycle; frame_err pulse only if state was LEN or PLD.
//   The output register still drains normally.
//  Strobe in the cycle of a state transition is consumed by the new state's counter.
//   No bit is ever lost or double-counted.
// STRUCTURE
//  Shared package rx_pkg:
//   - state encoding HUNT=2'd0, LEN=2'd1, PLD=2'd2
//   - DEFAULT_SYNC_WORD; header field widths (SYNC_W=32, LEN_W=16)
//  Sub-module rx_sync_corr: combinational 32-bit XOR+popcount giving match_pos and match_neg.
//  Top level: FSM, bit/byte counters, 1-entry output register.
// TESTING
//  1 Clean frame, sync 1ACFFC1D, len=3, bytes A5 3C FF, tready=1:
//    hdr_vld once; 3 beats A5/3C/FF; tuser on A5, tlast on FF; frame_cnt=1.
//  2 Same frame with all bits inverted: polarity=1; identical output bytes.
//  3 Sync with 2 flipped bits -> locks. Sync with 3 flipped bits (SYNC_TOL=2) -> no hdr_vld.
//  4 len=0 and then len=1025: each gives frame_err pulse, no beats, back to HUNT.
//    A following valid frame is received correctly.
//  5 len=4, tready=0 from the first beat, bits back-to-back:
//    frame_err at 2nd byte completion; byte 1 stays stable until tready=1; then no more beats.
//  6 rx_en dropped mid-payload: frame_err pulse, pld_vld=0.
//    Reset mid-frame: all outputs 0 immediately (async).

Source files
------------

// File: rtl/rx_pkg.sv
// Shared types and constants for the Rx deframer: FSM encoding, header field widths
// and the popcount helper used by the sync correlator.
package rx_pkg;

   localparam int unsigned SYNC_W = 32;
   localparam int unsigned LEN_W  = 16;
   localparam int unsigned BYTE_W = 8;

   localparam logic [SYNC_W-1:0] DEFAULT_SYNC_WORD = 32'h1ACF_FC1D;

   typedef enum logic [1:0] {
      StHunt = 2'd0,
      StLen  = 2'd1,
      StPld  = 2'd2
   } rx_state_e;

   function automatic logic [5:0] popcount32(input logic [SYNC_W-1:0] v);
      logic [5:0] cnt;
      cnt = '0;
      for (int i = 0; i < SYNC_W; i++) begin
         cnt = cnt + {5'd0, v[i]};
      end
      return cnt;
   endfunction

endpackage

// File: rtl/rx_sync_corr.sv
// Combinational sync-word correlator: Hamming distance of the shift register against the
// sync word in both polarities, thresholded by SYNC_TOL.
module rx_sync_corr
   import rx_pkg::*;
#(
   parameter logic [SYNC_W-1:0] SYNC_WORD = DEFAULT_SYNC_WORD,
   parameter int unsigned       SYNC_TOL  = 2
) (
   input  logic [SYNC_W-1:0] sreg,
   output logic              match_pos,
   output logic              match_neg
);

   logic [5:0] dist_pos;
   logic [5:0] dist_neg;

   always_comb begin
      dist_pos  = popcount32(sreg ^ SYNC_WORD);
      dist_neg  = popcount32(~sreg ^ SYNC_WORD);
      match_pos = ({26'd0, dist_pos} <= SYNC_TOL);
      // Tolerance below 8 keeps the two tests disjoint; priority just makes it explicit.
      match_neg = !match_pos && ({26'd0, dist_neg} <= SYNC_TOL);
   end

endmodule

// File: rtl/rx_deframer.sv
// Rx deframer: hunts for the sync word (either polarity), reads the 16-bit length field
// and streams the payload bytes out through a 1-entry AXI-Stream output register.
module rx_deframer
   import rx_pkg::*;
#(
   parameter logic [SYNC_W-1:0] SYNC_WORD = DEFAULT_SYNC_WORD,
   parameter int unsigned       SYNC_TOL  = 2,
   parameter logic [LEN_W-1:0]  MAX_LEN   = 16'd1024
) (
   input  logic              clk_16M384,
   input  logic              rst_16M384,
   input  logic              rx_en,
   input  logic              rx_bit,
   input  logic              rx_bit_vld,
   output logic [BYTE_W-1:0] rx_tdata,
   output logic              rx_tvalid,
   input  logic              rx_tready,
   output logic              rx_tlast,
   output logic              rx_tuser,
   output logic [LEN_W-1:0]  payload_length,
   output logic              hdr_vld,
   output logic              pld_vld,
   output logic              polarity,
   output logic              frame_err,
   output logic [15:0]       frame_cnt
);

   rx_state_e         state_q, state_d;
   logic [SYNC_W-1:0] sreg_q, sreg_d;
   logic              pol_q, pol_d;
   logic [LEN_W-1:0]  shift_q, shift_d;
   logic [3:0]        bit_cnt_q, bit_cnt_d;
   logic [LEN_W-1:0]  byte_num_q, byte_num_d;
   logic [LEN_W-1:0]  plen_q, plen_d;
   logic              hdr_vld_q, hdr_vld_d;
   logic              frame_err_q, frame_err_d;
   logic [15:0]       frame_cnt_q, frame_cnt_d;
   logic [BYTE_W-1:0] tdata_q, tdata_d;
   logic              tvalid_q, tvalid_d;
   logic              tlast_q, tlast_d;
   logic              tuser_q, tuser_d;

   logic [SYNC_W-1:0] sreg_shift;
   logic              match_pos;
   logic              match_neg;
   logic              data_bit;
   logic              last_byte;

   assign sreg_shift = {sreg_q[SYNC_W-2:0], rx_bit};

   rx_sync_corr #(
      .SYNC_WORD (SYNC_WORD),
      .SYNC_TOL  (SYNC_TOL)
   ) u_sync_corr (
      .sreg      (sreg_shift),
      .match_pos (match_pos),
      .match_neg (match_neg)
   );

   always_comb begin
      state_d     = state_q;
      sreg_d      = sreg_q;
      pol_d       = pol_q;
      shift_d     = shift_q;
      bit_cnt_d   = bit_cnt_q;
      byte_num_d  = byte_num_q;
      plen_d      = plen_q;
      hdr_vld_d   = 1'b0;
      frame_err_d = 1'b0;
      frame_cnt_d = frame_cnt_q;
      tdata_d     = tdata_q;
      tlast_d     = tlast_q;
      tuser_d     = tuser_q;
      // Output register drains on handshake; a load below overrides this.
      tvalid_d    = tvalid_q & ~rx_tready;
      data_bit    = rx_bit ^ pol_q;
      last_byte   = 1'b0;

      if (!rx_en) begin
         state_d     = StHunt;
         sreg_d      = '0;
         bit_cnt_d   = '0;
         frame_err_d = (state_q != StHunt);
      end else if (rx_bit_vld) begin
         unique case (state_q)
            StHunt: begin
               sreg_d = sreg_shift;
               if (match_pos) begin
                  pol_d     = 1'b0;
                  bit_cnt_d = '0;
                  state_d   = StLen;
               end else if (match_neg) begin
                  pol_d     = 1'b1;
                  bit_cnt_d = '0;
                  state_d   = StLen;
               end
            end

            StLen: begin
               shift_d   = {shift_q[LEN_W-2:0], data_bit};
               bit_cnt_d = bit_cnt_q + 4'd1;
               if (bit_cnt_q == 4'd15) begin
                  bit_cnt_d = '0;
                  if (shift_d == '0 || shift_d > MAX_LEN) begin
                     frame_err_d = 1'b1;
                     sreg_d      = '0;
                     state_d     = StHunt;
                  end else begin
                     plen_d     = shift_d;
                     hdr_vld_d  = 1'b1;
                     byte_num_d = '0;
                     state_d    = StPld;
                  end
               end
            end

            StPld: begin
               shift_d   = {shift_q[LEN_W-2:0], data_bit};
               bit_cnt_d = bit_cnt_q + 4'd1;
               if (bit_cnt_q == 4'd7) begin
                  bit_cnt_d = '0;
                  if (!tvalid_q || rx_tready) begin
                     last_byte  = (byte_num_q == plen_q - 16'd1);
                     tvalid_d   = 1'b1;
                     tdata_d    = shift_d[BYTE_W-1:0];
                     tuser_d    = (byte_num_q == '0);
                     tlast_d    = last_byte;
                     byte_num_d = byte_num_q + 16'd1;
                     if (last_byte) begin
                        frame_cnt_d = frame_cnt_q + 16'd1;
                        sreg_d      = '0;
                        state_d     = StHunt;
                     end
                  end else begin
                     // Overflow: held byte stays put, new byte is dropped, frame truncated.
                     frame_err_d = 1'b1;
                     sreg_d      = '0;
                     state_d     = StHunt;
                  end
               end
            end

            default: begin
               sreg_d  = '0;
               state_d = StHunt;
            end
         endcase
      end
   end

   always_ff @(posedge clk_16M384 or posedge rst_16M384) begin
      if (rst_16M384) begin
         state_q     <= StHunt;
         sreg_q      <= '0;
         pol_q       <= 1'b0;
         shift_q     <= '0;
         bit_cnt_q   <= '0;
         byte_num_q  <= '0;
         plen_q      <= '0;
         hdr_vld_q   <= 1'b0;
         frame_err_q <= 1'b0;
         frame_cnt_q <= '0;
         tdata_q     <= '0;
         tvalid_q    <= 1'b0;
         tlast_q     <= 1'b0;
         tuser_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         sreg_q      <= sreg_d;
         pol_q       <= pol_d;
         shift_q     <= shift_d;
         bit_cnt_q   <= bit_cnt_d;
         byte_num_q  <= byte_num_d;
         plen_q      <= plen_d;
         hdr_vld_q   <= hdr_vld_d;
         frame_err_q <= frame_err_d;
         frame_cnt_q <= frame_cnt_d;
         tdata_q     <= tdata_d;
         tvalid_q    <= tvalid_d;
         tlast_q     <= tlast_d;
         tuser_q     <= tuser_d;
      end
   end

   assign rx_tdata       = tdata_q;
   assign rx_tvalid      = tvalid_q;
   assign rx_tlast       = tlast_q;
   assign rx_tuser       = tuser_q;
   assign payload_length = plen_q;
   assign hdr_vld        = hdr_vld_q;
   assign pld_vld        = (state_q == StPld);
   assign polarity       = pol_q;
   assign frame_err      = frame_err_q;
   assign frame_cnt      = frame_cnt_q;

endmodule

// File: tb/tb_rx_deframer.sv
// Self-checking bench for rx_deframer: frames are bit-serialised, expected beats are queued
// as stimulus is driven and compared as the DUT hands them over.
module tb_rx_deframer;

   localparam logic [31:0] SYNC = 32'h1ACF_FC1D;

   typedef struct packed {
      logic [7:0] d;
      logic       u;
      logic       l;
   } beat_t;

   logic        clk;
   logic        rst;
   logic        rx_en;
   logic        rx_bit;
   logic        rx_bit_vld;
   logic [7:0]  rx_tdata;
   logic        rx_tvalid;
   logic        rx_tready;
   logic        rx_tlast;
   logic        rx_tuser;
   logic [15:0] payload_length;
   logic        hdr_vld;
   logic        pld_vld;
   logic        polarity;
   logic        frame_err;
   logic [15:0] frame_cnt;

   beat_t      exp_q[$];
   logic [7:0] pld [0:1023];
   int         checks;
   int         errors;
   int         hdr_cnt;
   int         ferr_cnt;

   rx_deframer dut (
      .clk_16M384     (clk),
      .rst_16M384     (rst),
      .rx_en          (rx_en),
      .rx_bit         (rx_bit),
      .rx_bit_vld     (rx_bit_vld),
      .rx_tdata       (rx_tdata),
      .rx_tvalid      (rx_tvalid),
      .rx_tready      (rx_tready),
      .rx_tlast       (rx_tlast),
      .rx_tuser       (rx_tuser),
      .payload_length (payload_length),
      .hdr_vld        (hdr_vld),
      .pld_vld        (pld_vld),
      .polarity       (polarity),
      .frame_err      (frame_err),
      .frame_cnt      (frame_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      checks++;
      if (obs !== exp_v) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", tag, obs, exp_v);
      end
   endtask

   // Scoreboard side: every handshake must match the oldest queued beat.
   always @(negedge clk) begin
      if (!rst) begin
         if (hdr_vld) hdr_cnt++;
         if (frame_err) ferr_cnt++;
         if (rx_tvalid && rx_tready) begin
            check("beat_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
               beat_t e;
               e = exp_q.pop_front();
               check("beat", {22'd0, rx_tdata, rx_tuser, rx_tlast}, {22'd0, e.d, e.u, e.l});
            end
         end
      end
   end

   task automatic send_bit(input logic b);
      @(posedge clk);
      #1;
      rx_bit     = b;
      rx_bit_vld = 1'b1;
   endtask

   task automatic idle(input int n);
      @(posedge clk);
      #1;
      rx_bit_vld = 1'b0;
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Sends sync, length and the first nbits payload bits of pld[]; queues n_exp beats.
   task automatic send_frame(input logic [31:0] sync, input logic inv, input logic [15:0] len,
                             input int nbits, input int n_exp);
      logic [7:0] b;
      for (int i = 0; i < n_exp; i++) begin
         exp_q.push_back('{d: pld[i], u: (i == 0), l: (i == int'(len) - 1)});
      end
      for (int i = 31; i >= 0; i--) send_bit(sync[i] ^ inv);
      for (int i = 15; i >= 0; i--) send_bit(len[i] ^ inv);
      for (int k = 0; k < nbits; k++) begin
         b = pld[k / 8];
         send_bit(b[7 - (k % 8)] ^ inv);
      end
      @(posedge clk);
      #1;
      rx_bit_vld = 1'b0;
   endtask

   initial begin
      checks     = 0;
      errors     = 0;
      hdr_cnt    = 0;
      ferr_cnt   = 0;
      rst        = 1'b1;
      rx_en      = 1'b1;
      rx_bit     = 1'b0;
      rx_bit_vld = 1'b0;
      rx_tready  = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("reset_outputs", {7'd0, rx_tvalid, rx_tlast, rx_tuser, hdr_vld, pld_vld, polarity,
                              frame_err, payload_length}, 32'd0);
      check("reset_frame_cnt", 32'(frame_cnt), 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      idle(2);

      // 1: clean frame
      pld[0] = 8'hA5; pld[1] = 8'h3C; pld[2] = 8'hFF;
      send_frame(SYNC, 1'b0, 16'd3, 24, 3);
      idle(4);
      check("t1_hdr_cnt", 32'(hdr_cnt), 32'd1);
      check("t1_frame_cnt", 32'(frame_cnt), 32'd1);
      check("t1_len", 32'(payload_length), 32'd3);
      check("t1_pol", 32'(polarity), 32'd0);
      check("t1_drained", 32'(exp_q.size()), 32'd0);

      // 2: inverted frame
      send_frame(SYNC, 1'b1, 16'd3, 24, 3);
      idle(4);
      check("t2_pol", 32'(polarity), 32'd1);
      check("t2_frame_cnt", 32'(frame_cnt), 32'd2);
      check("t2_drained", 32'(exp_q.size()), 32'd0);

      // 3: sync tolerance boundary
      pld[0] = 8'h42;
      send_frame(SYNC ^ 32'h0002_0001, 1'b0, 16'd1, 8, 1);
      idle(4);
      check("t3_2err_hdr", 32'(hdr_cnt), 32'd3);
      check("t3_2err_cnt", 32'(frame_cnt), 32'd3);
      send_frame(SYNC ^ 32'h8002_0001, 1'b0, 16'd1, 8, 0);
      idle(4);
      check("t3_3err_hdr", 32'(hdr_cnt), 32'd3);
      check("t3_3err_cnt", 32'(frame_cnt), 32'd3);
      rx_en = 1'b0;
      idle(1);
      rx_en = 1'b1;
      idle(2);
      check("t3_hunt_abort_no_err", 32'(ferr_cnt), 32'd0);

      // 4: bad lengths, then good frames including MAX_LEN
      send_frame(SYNC, 1'b0, 16'd0, 0, 0);
      idle(3);
      check("t4_len0_err", 32'(ferr_cnt), 32'd1);
      send_frame(SYNC, 1'b0, 16'd1025, 0, 0);
      idle(3);
      check("t4_len1025_err", 32'(ferr_cnt), 32'd2);
      check("t4_len_kept", 32'(payload_length), 32'd1);
      check("t4_no_hdr", 32'(hdr_cnt), 32'd3);
      pld[0] = 8'h11; pld[1] = 8'h22;
      send_frame(SYNC, 1'b0, 16'd2, 16, 2);
      idle(4);
      check("t4_good_cnt", 32'(frame_cnt), 32'd4);
      for (int i = 0; i < 1024; i++) pld[i] = 8'(i * 7 + 3);
      send_frame(SYNC, 1'b0, 16'd1024, 8192, 1024);
      idle(4);
      check("t4_max_cnt", 32'(frame_cnt), 32'd5);
      check("t4_max_len", 32'(payload_length), 32'd1024);
      check("t4_drained", 32'(exp_q.size()), 32'd0);

      // 5: overflow with back-pressure
      pld[0] = 8'h5A; pld[1] = 8'hC3; pld[2] = 8'h99; pld[3] = 8'h66;
      rx_tready = 1'b0;
      send_frame(SYNC, 1'b0, 16'd4, 32, 1);
      idle(2);
      check("t5_ovf_err", 32'(ferr_cnt), 32'd3);
      check("t5_pld_vld", 32'(pld_vld), 32'd0);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check("t5_held", {22'd0, rx_tdata, rx_tvalid, rx_tuser}, {22'd0, 8'h5A, 1'b1, 1'b1});
      end
      rx_tready = 1'b1;
      idle(6);
      check("t5_drained", 32'(exp_q.size()), 32'd0);
      check("t5_tvalid", 32'(rx_tvalid), 32'd0);
      check("t5_frame_cnt", 32'(frame_cnt), 32'd5);

      // 6: abort mid-payload, then async reset mid-frame
      send_frame(SYNC, 1'b0, 16'd4, 12, 1);
      check("t6_in_pld", 32'(pld_vld), 32'd1);
      rx_en = 1'b0;
      @(posedge clk);
      @(negedge clk);
      check("t6_abort", {30'd0, frame_err, pld_vld}, {30'd0, 1'b1, 1'b0});
      rx_en = 1'b1;
      idle(4);
      check("t6_ferr_cnt", 32'(ferr_cnt), 32'd4);
      check("t6_drained", 32'(exp_q.size()), 32'd0);

      rx_tready = 1'b0;
      send_frame(SYNC, 1'b1, 16'd4, 8, 0);
      idle(1);
      check("t6_pre_rst", {29'd0, rx_tvalid, polarity, pld_vld}, {29'd0, 3'b111});
      #2;
      rst = 1'b1;
      #1;
      check("t6_rst_outputs", {7'd0, rx_tvalid, rx_tlast, rx_tuser, hdr_vld, pld_vld, polarity,
                               frame_err, payload_length}, 32'd0);
      check("t6_rst_frame_cnt", 32'(frame_cnt), 32'd0);
      @(posedge clk);
      #1;
      rst       = 1'b0;
      rx_tready = 1'b1;
      idle(3);
      check("t6_post_rst_quiet", 32'(rx_tvalid), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
